// File: rtl/alu_seq_if.sv
// Request/response bundle between the core sequencer and alu_seq.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             v_in;
  logic             decimal_en;
  logic [WIDTH-1:0] y;
  logic             carry_out;
  logic             v_out;
  logic             z_out;
  logic             n_out;
  logic             out_valid;

  modport master (
    output in_valid, opcode, a, b, carry_in, v_in, decimal_en,
    input  in_ready, y, carry_out, v_out, z_out, n_out, out_valid
  );
  modport slave (
    input  in_valid, opcode, a, b, carry_in, v_in, decimal_en,
    output in_ready, y, carry_out, v_out, z_out, n_out, out_valid
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with binary ops in one cycle and 6502-style BCD ADD/SUB
// processed one nibble per cycle, with N/V/Z/C flags and valid/ready handshake.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic   clk,
  input logic   rst,
  alu_seq_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int M   = WIDTH - 1;

  localparam logic [7:0] OP_AND = 8'h01, OP_OR  = 8'h02, OP_XOR = 8'h03, OP_NOT = 8'h04;
  localparam logic [7:0] OP_ASL = 8'h11, OP_ROL = 8'h12, OP_LSR = 8'h13, OP_ROR = 8'h14;
  localparam logic [7:0] OP_ADD = 8'h21, OP_INC = 8'h22, OP_SUB = 8'h23, OP_DEC = 8'h24;
  localparam logic [7:0] OP_CMP = 8'h25, OP_NOP = 8'h32;

  typedef enum logic [1:0] {IDLE, EXEC, BCD} state_t;
  state_t state;

  logic [7:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, bcd_acc;
  logic             cin_q, vin_q, bcd_c;
  logic [CW-1:0]    nib_cnt;

  logic [WIDTH:0]   add_w, sub_w, cmp_w;
  logic             add_v, sub_v;
  assign add_w = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, ~cin_q};
  assign cmp_w = {1'b0, a_q} - {1'b0, b_q};
  assign add_v = (a_q[M] == b_q[M]) && (add_w[M] != a_q[M]);
  assign sub_v = (a_q[M] != b_q[M]) && (sub_w[M] != a_q[M]);

  logic [WIDTH-1:0] res_y;
  logic             res_c, res_v, res_z, res_n;
  always_comb begin
    res_y = a_q;
    res_c = cin_q;
    res_v = vin_q;
    case (op_q)
      OP_AND: res_y = a_q & b_q;
      OP_OR:  res_y = a_q | b_q;
      OP_XOR: res_y = a_q ^ b_q;
      OP_NOT: res_y = ~a_q;
      OP_ASL: begin res_y = {a_q[M-1:0], 1'b0}; res_c = a_q[M]; end
      OP_ROL: begin res_y = {a_q[M-1:0], cin_q}; res_c = a_q[M]; end
      OP_LSR: begin res_y = {1'b0, a_q[M:1]};    res_c = a_q[0]; end
      OP_ROR: begin res_y = {cin_q, a_q[M:1]};   res_c = a_q[0]; end
      OP_ADD: begin res_y = add_w[M:0]; res_c = add_w[WIDTH];  res_v = add_v; end
      OP_SUB: begin res_y = sub_w[M:0]; res_c = ~sub_w[WIDTH]; res_v = sub_v; end
      OP_INC: res_y = a_q + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DEC: res_y = a_q - {{(WIDTH-1){1'b0}}, 1'b1};
      OP_CMP: res_c = ~cmp_w[WIDTH];
      default: ;
    endcase
    res_z = (res_y == '0);
    res_n = res_y[M];
    // CMP reports the flags of a-b but leaves y = a
    if (op_q == OP_CMP) begin
      res_z = (a_q == b_q);
      res_n = cmp_w[M];
    end
  end

  // bcd_c holds the carry for ADD and the borrow for SUB
  logic [CW+1:0]    nib_base;
  logic [3:0]       nib_a, nib_b, nib_r;
  logic [4:0]       add5, sub5;
  logic             nib_c, nib_last;
  logic [WIDTH-1:0] acc_nx;
  assign nib_base = {nib_cnt, 2'b00};
  assign nib_a    = a_q[nib_base +: 4];
  assign nib_b    = b_q[nib_base +: 4];
  assign add5     = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, bcd_c};
  assign sub5     = {1'b0, nib_a} - {1'b0, nib_b} - {4'b0, bcd_c};
  assign nib_last = (nib_cnt == CW'(NIB - 1));

  always_comb begin
    nib_r = add5[3:0];
    nib_c = 1'b0;
    if (op_q == OP_ADD) begin
      if (add5 > 5'd9) begin nib_r = add5[3:0] + 4'd6; nib_c = 1'b1; end
    end else begin
      nib_r = sub5[3:0];
      if (sub5[4]) begin nib_r = sub5[3:0] - 4'd6; nib_c = 1'b1; end
    end
    acc_nx = bcd_acc;
    acc_nx[nib_base +: 4] = nib_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.y         <= '0;
      bus.carry_out <= 1'b0;
      bus.v_out     <= 1'b0;
      bus.z_out     <= 1'b0;
      bus.n_out     <= 1'b0;
      bus.out_valid <= 1'b0;
      nib_cnt       <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cin_q         <= 1'b0;
      vin_q         <= 1'b0;
      bcd_c         <= 1'b0;
      bcd_acc       <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q         <= bus.opcode;
          a_q          <= bus.a;
          b_q          <= bus.b;
          cin_q        <= bus.carry_in;
          vin_q        <= bus.v_in;
          bus.in_ready <= 1'b0;
          nib_cnt      <= '0;
          bcd_acc      <= '0;
          bcd_c        <= (bus.opcode == OP_ADD) ? bus.carry_in : ~bus.carry_in;
          if (bus.decimal_en && (bus.opcode == OP_ADD || bus.opcode == OP_SUB))
            state <= BCD;
          else
            state <= EXEC;
        end
        EXEC: begin
          if (op_q != OP_NOP) begin
            bus.y         <= res_y;
            bus.carry_out <= res_c;
            bus.v_out     <= res_v;
            bus.z_out     <= res_z;
            bus.n_out     <= res_n;
          end
          bus.out_valid <= 1'b1;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        BCD: begin
          bcd_acc <= acc_nx;
          bcd_c   <= nib_c;
          if (nib_last) begin
            bus.y         <= acc_nx;
            bus.carry_out <= (op_q == OP_ADD) ? nib_c : ~nib_c;
            bus.v_out     <= (op_q == OP_ADD) ? add_v : sub_v;
            bus.z_out     <= (acc_nx == '0);
            bus.n_out     <= acc_nx[M];
            bus.out_valid <= 1'b1;
            bus.in_ready  <= 1'b1;
            nib_cnt       <= '0;
            state         <= IDLE;
          end else begin
            nib_cnt <= nib_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed checks of alu_seq at WIDTH=8 and WIDTH=16 with hand-computed results.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst8, rst16;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(16)) b16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(b8.slave));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .bus(b16.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one request, accept it on the next edge, then scramble the inputs.
  task automatic op8(input logic [7:0] opc, input logic [7:0] aa, input logic [7:0] bb,
                     input logic c, input logic v, input logic d);
    @(negedge clk);
    b8.opcode = opc; b8.a = aa; b8.b = bb;
    b8.carry_in = c; b8.v_in = v; b8.decimal_en = d; b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    b8.a = 8'($urandom); b8.b = 8'($urandom); b8.opcode = 8'h04;
    b8.carry_in = ~c; b8.v_in = ~v; b8.decimal_en = ~d;
  endtask

  task automatic res8(input string tag, input logic [7:0] ey,
                      input logic ec, input logic ev, input logic ez, input logic en);
    chk({tag, ".ov"}, 32'(b8.out_valid), 32'd1);
    chk({tag, ".y"},  32'(b8.y), 32'(ey));
    chk({tag, ".cvzn"}, 32'({b8.carry_out, b8.v_out, b8.z_out, b8.n_out}),
        32'({ec, ev, ez, en}));
  endtask

  initial begin
    b8.in_valid = 0; b8.opcode = 0; b8.a = 0; b8.b = 0;
    b8.carry_in = 0; b8.v_in = 0; b8.decimal_en = 0;
    b16.in_valid = 0; b16.opcode = 0; b16.a = 0; b16.b = 0;
    b16.carry_in = 0; b16.v_in = 0; b16.decimal_en = 0;
    rst8 = 1; rst16 = 1;
    tick(); tick();
    chk("rst.rdy", 32'(b8.in_ready), 32'd1);
    chk("rst.ov",  32'(b8.out_valid), 32'd0);
    chk("rst.y",   32'(b8.y), 32'd0);
    chk("rst.flags", 32'({b8.carry_out, b8.v_out, b8.z_out, b8.n_out}), 32'd0);
    @(negedge clk); rst8 = 0; rst16 = 0;

    // Binary ADD: 0x50+0x50 = 0xA0, signed overflow
    op8(8'h21, 8'h50, 8'h50, 0, 0, 0);
    chk("add.rdy0", 32'(b8.in_ready), 32'd0);
    chk("add.ov0",  32'(b8.out_valid), 32'd0);
    tick();
    res8("add", 8'hA0, 0, 1, 0, 1);
    chk("add.rdy1", 32'(b8.in_ready), 32'd1);
    tick();
    chk("add.ov2", 32'(b8.out_valid), 32'd0);

    // Decimal ADD: 58+46+1 = 105 -> 0x05 carry 1; binary 0x9F overflows
    op8(8'h21, 8'h58, 8'h46, 1, 0, 1);
    chk("dadd.rdy0", 32'(b8.in_ready), 32'd0);
    tick();
    chk("dadd.rdy1", 32'(b8.in_ready), 32'd0);
    chk("dadd.ov1",  32'(b8.out_valid), 32'd0);
    chk("dadd.hold", 32'(b8.y), 32'hA0);
    tick();
    res8("dadd", 8'h05, 1, 1, 0, 0);
    tick();
    chk("dadd.ov3", 32'(b8.out_valid), 32'd0);

    // Decimal SUB: 12-21 = 91 with borrow
    op8(8'h23, 8'h12, 8'h21, 1, 0, 1);
    tick(); tick();
    res8("dsub", 8'h91, 0, 0, 0, 1);

    // CMP equal and less-than; v_in passes through
    op8(8'h25, 8'h40, 8'h40, 0, 0, 0);
    tick();
    res8("cmp_eq", 8'h40, 1, 0, 1, 0);
    op8(8'h25, 8'h40, 8'h41, 0, 1, 0);
    tick();
    res8("cmp_lt", 8'h40, 0, 1, 0, 1);

    // Binary SUB: 0x00-0x01 = 0xFF, borrow
    op8(8'h23, 8'h00, 8'h01, 1, 0, 0);
    tick();
    res8("sub", 8'hFF, 0, 0, 0, 1);

    // ASL: 0x81 -> 0x02, C from msb
    op8(8'h11, 8'h81, 8'h00, 0, 0, 0);
    tick();
    res8("asl", 8'h02, 1, 0, 0, 0);

    // Unknown opcode acts as PASS_A; C and V pass through
    op8(8'hFF, 8'h00, 8'h33, 1, 1, 0);
    tick();
    res8("pass", 8'h00, 1, 1, 1, 0);

    // ROR with carry in, then NOP keeps everything
    op8(8'h14, 8'h01, 8'h00, 1, 0, 0);
    tick();
    res8("ror", 8'h80, 1, 0, 0, 1);
    op8(8'h32, 8'h55, 8'h00, 0, 1, 0);
    tick();
    res8("nop", 8'h80, 1, 0, 0, 1);
    tick();
    chk("nop.ov2", 32'(b8.out_valid), 32'd0);

    // 16-bit decimal ADD dropped by reset after edge 2
    @(negedge clk);
    b16.opcode = 8'h21; b16.a = 16'h1234; b16.b = 16'h5678;
    b16.carry_in = 0; b16.decimal_en = 1; b16.in_valid = 1;
    tick();
    b16.in_valid = 0;
    tick(); tick();
    chk("w16.ov2",  32'(b16.out_valid), 32'd0);
    chk("w16.rdy2", 32'(b16.in_ready), 32'd0);
    @(negedge clk); rst16 = 1;
    tick();
    chk("w16.rst.ov",  32'(b16.out_valid), 32'd0);
    chk("w16.rst.y",   32'(b16.y), 32'd0);
    chk("w16.rst.rdy", 32'(b16.in_ready), 32'd1);
    @(negedge clk); rst16 = 0;
    tick();
    chk("w16.after.ov", 32'(b16.out_valid), 32'd0);

    // 16-bit binary ADD 0xFFFF+1 wraps to zero with carry
    @(negedge clk);
    b16.opcode = 8'h21; b16.a = 16'hFFFF; b16.b = 16'h0001;
    b16.carry_in = 0; b16.v_in = 0; b16.decimal_en = 0; b16.in_valid = 1;
    tick();
    b16.in_valid = 0; b16.a = 16'h1111;
    tick();
    chk("w16.add.ov", 32'(b16.out_valid), 32'd1);
    chk("w16.add.y",  32'(b16.y), 32'd0);
    chk("w16.add.cvzn", 32'({b16.carry_out, b16.v_out, b16.z_out, b16.n_out}), 32'b1010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the 6502 core's combinational ALU. It adds:
- operand width as a parameter;
- 6502 decimal (BCD) mode for ADD/SUB, processed one nibble per cycle;
- full N/V/Z/C flag generation, including CMP;
- a valid/ready handshake toward the core sequencer.

It sits between the register file/operand latches and the status register.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4, minimum 4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE; the operation is accepted on an edge where in_valid && in_ready.
- opcode  in  8  operation code (list below).
- a, b  in  WIDTH  operands.
- carry_in  in  1  C flag in.
- v_in  in  1  V flag in.
- decimal_en  in  1  D flag; affects ADD/SUB only.
- y  out  WIDTH  registered result.
- carry_out, v_out, z_out, n_out  out  1  registered flags.
- out_valid  out  1  single-cycle pulse; outputs hold until the next completion.

## Operation
Opcodes; any other value behaves as PASS_A:
- Logic: AND 0x01, OR 0x02, XOR 0x03, NOT 0x04 (~a).
- Shift/rotate: ASL 0x11, ROL 0x12, LSR 0x13, ROR 0x14.
- Arithmetic: ADD 0x21, INC 0x22, SUB 0x23, DEC 0x24, CMP 0x25.
- Other: PASS_A 0x31, NOP 0x32.

Operand and control capture:
- a, b, opcode, carry_in, v_in and decimal_en are latched at the accept edge.
- Later input changes have no effect on an accepted operation.

Binary arithmetic:
- ADD: {C,y} = a+b+cin, computed at WIDTH+1 bits.
- SUB: a-b-(1-cin); C = no borrow.
- V = signed overflow of the WIDTH-bit result.
- INC and DEC do not use carry_in.

CMP:
- Computes a-b with the borrow-in forced to 0.
- y = a (unchanged).
- C = (a>=b unsigned); Z = (a==b); N = msb of (a-b).

Shifts and rotates:
- ASL: C = a[msb].
- ROL: y = {a[W-2:0], cin}; C = a[msb].
- LSR: y = a>>1; C = a[0].
- ROR: y = {cin, a[W-1:1]}; C = a[0].

Flag defaults:
- Z = (y==0) and N = y[msb] for every op except CMP and NOP.
- C passes carry_in for ops that do not define it: logic ops, INC, DEC, PASS_A.
- V passes v_in for every op except ADD/SUB.

NOP: y and all flags hold their previous registered values; out_valid still pulses.

Decimal mode (decimal_en=1, ADD/SUB only):
- Nibble-serial, LSB nibble first, one nibble per cycle; nibble carry is chained through a register.
- ADD per nibble: s = an+bn+c; if s>9 then s = s+6 and c = 1, else c = 0; keep s[3:0].
- SUB per nibble: d = an-bn-borrow; if d<0 then d = d-6 (mod 16) and borrow = 1, else borrow = 0.
- C = final carry, or ~final borrow for SUB.
- Z and N are taken from the BCD result.
- V is the binary-mode V for the same latched operands.
- Non-BCD digits follow the same rule with no error indication.

State machine:
- IDLE -> EXEC on accept, when the op is binary.
- IDLE -> BCD on accept, when decimal_en=1 and the op is ADD/SUB.
- EXEC -> IDLE after 1 cycle; registers the result and pulses out_valid.
- BCD stays for NIB = WIDTH/4 cycles, counter 0..NIB-1, then -> IDLE. The last nibble registers y/flags and pulses out_valid.

## Timing
- Reset values: state IDLE; in_ready 1; y 0; all flags 0; out_valid 0; nibble counter 0.
- Binary latency: accept at edge 0; result registered at edge 1; out_valid high between edges 1 and 2.
- Binary throughput: in_ready is high again after edge 1, so the next accept is possible at edge 2.
- Decimal latency: result and out_valid registered at edge NIB (WIDTH=8: edge 2).
- in_ready is low for the whole of EXEC/BCD; in_valid is ignored there.
- Reset asserted mid-operation: the operation is dropped, no out_valid is produced, all outputs return to reset values on that edge.
- rst overrides in_valid on the same edge.
- y is never partially updated during BCD: nibbles accumulate in an internal register.

## Test plan
- WIDTH=8, ADD binary, a=0x50, b=0x50, cin=0 -> y=0xA0, V=1, N=1, C=0, Z=0; out_valid exactly 1 cycle, at edge 1 after accept.
- WIDTH=8, ADD decimal, a=0x58, b=0x46, cin=1 -> y=0x05, C=1, Z=0; out_valid at edge 2; in_ready low for edges 0..2.
- WIDTH=8, SUB decimal, a=0x12, b=0x21, cin=1 -> y=0x91, C=0, N=1.
- WIDTH=8, CMP, a=0x40, b=0x40 -> y=0x40, Z=1, C=1, N=0. Repeat with b=0x41 -> C=0, N=1, Z=0.
- WIDTH=8, ROR, a=0x01, cin=1 -> y=0x80, C=1, N=1. Follow with NOP -> y=0x80 and flags unchanged, out_valid pulses.
- WIDTH=16, decimal ADD, rst pulsed after edge 2 -> no out_valid, y=0, in_ready=1 the following cycle; a fresh binary ADD 0xFFFF+0x0001 -> y=0x0000, C=1, Z=1.
